// File: rtl/k005297_cmd_sched.sv
// Command scheduler for the K005297 bubble memory controller: rotation ring,
// host/aux round-robin arbitration and command tracking to done/error/timeout.
module k005297_cmd_sched #(
    parameter int PAGE_W      = 12,
    parameter int TIMEOUT_ROT = 4095
) (
    input  logic              i_MCLK,
    input  logic              i_RST,
    input  logic              i_CLK2M_PCEN_n,
    output logic [19:0]       o_ROT20_n,
    input  logic              i_HOST_REQ,
    input  logic              i_HOST_WR,
    input  logic [PAGE_W-1:0] i_HOST_PAGE,
    output logic              o_HOST_ACK,
    input  logic              i_AUX_REQ,
    input  logic              i_AUX_WR,
    input  logic [PAGE_W-1:0] i_AUX_PAGE,
    output logic              o_AUX_ACK,
    output logic              o_CMDREG_RDREQ,
    output logic              o_CMDREG_WRREQ,
    output logic [PAGE_W-1:0] o_CMD_PAGE,
    input  logic              i_CMD_ACCEPTED_n,
    input  logic              i_CMDREG_RST_n,
    input  logic              i_FSMERR_RESTART_n,
    input  logic              i_ERR_CLR,
    output logic              o_BUSY,
    output logic              o_DONE,
    output logic              o_ERR,
    output logic              o_TIMEOUT,
    output logic              o_GRANT_AUX
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    // Abort fires on the wrap that would bring the counter to TIMEOUT_ROT.
    localparam logic [11:0] TIMEOUT_LAST = 12'(TIMEOUT_ROT - 1);

    state_t            state_reg, state_next;
    logic [19:0]       rot_reg, rot_next;
    logic [11:0]       cnt_reg, cnt_next;
    logic              rdreq_reg, rdreq_next;
    logic              wrreq_reg, wrreq_next;
    logic [PAGE_W-1:0] page_reg, page_next;
    logic              host_ack_reg, host_ack_next;
    logic              aux_ack_reg, aux_ack_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;
    logic              timeout_reg, timeout_next;
    logic              grant_aux_reg, grant_aux_next;
    logic              last_aux_reg, last_aux_next;

    logic tick;
    logic wrap;
    logic timeout_hit;
    logic pick_aux;
    logic sel_wr;

    assign tick        = ~i_CLK2M_PCEN_n;
    assign wrap        = ~rot_reg[19];
    assign timeout_hit = wrap && (cnt_reg >= TIMEOUT_LAST);

    // Active-low ring: each bit takes its lower neighbour, phase 19 feeds phase 0.
    assign rot_next[0] = rot_reg[19];
    genvar gi;
    generate
        for (gi = 1; gi < 20; gi++) begin : g_ring
            assign rot_next[gi] = rot_reg[gi-1];
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        rdreq_next     = rdreq_reg;
        wrreq_next     = wrreq_reg;
        page_next      = page_reg;
        host_ack_next  = 1'b0;
        aux_ack_next   = 1'b0;
        done_next      = 1'b0;
        err_next       = err_reg & ~i_ERR_CLR;
        timeout_next   = timeout_reg & ~i_ERR_CLR;
        grant_aux_next = grant_aux_reg;
        last_aux_next  = last_aux_reg;
        cnt_next       = cnt_reg;
        pick_aux       = 1'b0;
        sel_wr         = 1'b0;

        if (state_reg != ST_IDLE && wrap && cnt_reg != 12'hFFF) begin
            cnt_next = cnt_reg + 12'd1;
        end

        case (state_reg)
            ST_IDLE: begin
                if (!err_reg && !timeout_reg && (i_HOST_REQ || i_AUX_REQ)) begin
                    // On a tie the port that did not win last time goes first.
                    pick_aux       = i_AUX_REQ && (!i_HOST_REQ || !last_aux_reg);
                    sel_wr         = pick_aux ? i_AUX_WR : i_HOST_WR;
                    page_next      = pick_aux ? i_AUX_PAGE : i_HOST_PAGE;
                    rdreq_next     = ~sel_wr;
                    wrreq_next     = sel_wr;
                    host_ack_next  = ~pick_aux;
                    aux_ack_next   = pick_aux;
                    grant_aux_next = pick_aux;
                    last_aux_next  = pick_aux;
                    cnt_next       = 12'd0;
                    state_next     = ST_ISSUE;
                end
            end
            ST_ISSUE, ST_ACTIVE: begin
                if (!i_FSMERR_RESTART_n) begin
                    rdreq_next = 1'b0;
                    wrreq_next = 1'b0;
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                end else if (!i_CMDREG_RST_n) begin
                    // Completion seen in ISSUE implies the accept was folded in.
                    rdreq_next = 1'b0;
                    wrreq_next = 1'b0;
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end else if (timeout_hit) begin
                    rdreq_next   = 1'b0;
                    wrreq_next   = 1'b0;
                    timeout_next = 1'b1;
                    state_next   = ST_IDLE;
                end else if (state_reg == ST_ISSUE && !i_CMD_ACCEPTED_n) begin
                    state_next = ST_ACTIVE;
                end
            end
            default: begin
                rdreq_next = 1'b0;
                wrreq_next = 1'b0;
                state_next = ST_IDLE;
            end
        endcase

        busy_next = (state_next != ST_IDLE);
    end

    always_ff @(posedge i_MCLK) begin
        if (i_RST) begin
            state_reg     <= ST_IDLE;
            rot_reg       <= 20'hFFFFE;
            cnt_reg       <= 12'd0;
            rdreq_reg     <= 1'b0;
            wrreq_reg     <= 1'b0;
            page_reg      <= '0;
            host_ack_reg  <= 1'b0;
            aux_ack_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            timeout_reg   <= 1'b0;
            grant_aux_reg <= 1'b0;
            last_aux_reg  <= 1'b1;
        end else if (tick) begin
            state_reg     <= state_next;
            rot_reg       <= rot_next;
            cnt_reg       <= cnt_next;
            rdreq_reg     <= rdreq_next;
            wrreq_reg     <= wrreq_next;
            page_reg      <= page_next;
            host_ack_reg  <= host_ack_next;
            aux_ack_reg   <= aux_ack_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
            timeout_reg   <= timeout_next;
            grant_aux_reg <= grant_aux_next;
            last_aux_reg  <= last_aux_next;
        end
    end

    assign o_ROT20_n      = rot_reg;
    assign o_HOST_ACK     = host_ack_reg;
    assign o_AUX_ACK      = aux_ack_reg;
    assign o_CMDREG_RDREQ = rdreq_reg;
    assign o_CMDREG_WRREQ = wrreq_reg;
    assign o_CMD_PAGE     = page_reg;
    assign o_BUSY         = busy_reg;
    assign o_DONE         = done_reg;
    assign o_ERR          = err_reg;
    assign o_TIMEOUT      = timeout_reg;
    assign o_GRANT_AUX    = grant_aux_reg;

endmodule

// File: tb/tb_k005297_cmd_sched.sv
// Directed, table-driven bench for k005297_cmd_sched (built with TIMEOUT_ROT=2
// so the rotation timeout is reachable in a short run).
module tb_k005297_cmd_sched;

    typedef struct packed {
        logic        rst;
        logic        pcen_n;
        logic        hreq;
        logic        hwr;
        logic [11:0] hpage;
        logic        areq;
        logic        awr;
        logic [11:0] apage;
        logic        acc_n;
        logic        crst_n;
        logic        ferr_n;
        logic        eclr;
    } in_t;

    typedef struct packed {
        logic        hack;
        logic        aack;
        logic        rd;
        logic        wr;
        logic [11:0] page;
        logic        busy;
        logic        done;
        logic        err;
        logic        to;
        logic        gaux;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    // {acc_n, crst_n, ferr_n, eclr}
    localparam logic [3:0] F_NONE    = 4'b1110;
    localparam logic [3:0] F_ACC     = 4'b0110;
    localparam logic [3:0] F_RST     = 4'b1010;
    localparam logic [3:0] F_ERR_RST = 4'b1000;
    localparam logic [3:0] F_CLR     = 4'b1111;
    localparam logic [3:0] F_ERR_CLR = 4'b1101;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pcen_n = 1'b0;
    logic [19:0] rot_n;
    logic        host_req = 1'b0, host_wr = 1'b0;
    logic [11:0] host_page = 12'h000;
    logic        host_ack;
    logic        aux_req = 1'b0, aux_wr = 1'b0;
    logic [11:0] aux_page = 12'h000;
    logic        aux_ack;
    logic        rdreq, wrreq;
    logic [11:0] cmd_page;
    logic        acc_n = 1'b1, crst_n = 1'b1, ferr_n = 1'b1, err_clr = 1'b0;
    logic        busy, done, err, tmo, grant_aux;

    int checks = 0;
    int errors = 0;
    int phase  = 0;
    int step   = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    k005297_cmd_sched #(.PAGE_W(12), .TIMEOUT_ROT(2)) dut (
        .i_MCLK             (clk),
        .i_RST              (rst),
        .i_CLK2M_PCEN_n     (pcen_n),
        .o_ROT20_n          (rot_n),
        .i_HOST_REQ         (host_req),
        .i_HOST_WR          (host_wr),
        .i_HOST_PAGE        (host_page),
        .o_HOST_ACK         (host_ack),
        .i_AUX_REQ          (aux_req),
        .i_AUX_WR           (aux_wr),
        .i_AUX_PAGE         (aux_page),
        .o_AUX_ACK          (aux_ack),
        .o_CMDREG_RDREQ     (rdreq),
        .o_CMDREG_WRREQ     (wrreq),
        .o_CMD_PAGE         (cmd_page),
        .i_CMD_ACCEPTED_n   (acc_n),
        .i_CMDREG_RST_n     (crst_n),
        .i_FSMERR_RESTART_n (ferr_n),
        .i_ERR_CLR          (err_clr),
        .o_BUSY             (busy),
        .o_DONE             (done),
        .o_ERR              (err),
        .o_TIMEOUT          (tmo),
        .o_GRANT_AUX        (grant_aux)
    );

    // rp = {rst, pcen_n}; h/a = {req, wr}; f = {acc_n, crst_n, ferr_n, eclr}
    function automatic in_t mi(input logic [1:0] rp, input logic [1:0] h, input logic [11:0] hp,
                               input logic [1:0] a, input logic [11:0] ap, input logic [3:0] f);
        in_t r;
        r.rst = rp[1]; r.pcen_n = rp[0];
        r.hreq = h[1]; r.hwr = h[0]; r.hpage = hp;
        r.areq = a[1]; r.awr = a[0]; r.apage = ap;
        r.acc_n = f[3]; r.crst_n = f[2]; r.ferr_n = f[1]; r.eclr = f[0];
        return r;
    endfunction

    // r = {hack, aack, rd, wr}; s = {busy, done, err, timeout, grant_aux}
    function automatic exp_t me(input logic [3:0] r, input logic [11:0] pg, input logic [4:0] s);
        exp_t x;
        x.hack = r[3]; x.aack = r[2]; x.rd = r[1]; x.wr = r[0];
        x.page = pg;
        x.busy = s[4]; x.done = s[3]; x.err = s[2]; x.to = s[1]; x.gaux = s[0];
        return x;
    endfunction

    task automatic add(input in_t i, input exp_t e);
        vec_t v;
        v.i = i;
        v.e = e;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at step %0d: got %h, expected %h", name, step, act, req);
        end
    endtask

    task automatic apply(input in_t i, input exp_t e);
        logic [19:0] exp_rot;
        rst       = i.rst;
        pcen_n    = i.pcen_n;
        host_req  = i.hreq;
        host_wr   = i.hwr;
        host_page = i.hpage;
        aux_req   = i.areq;
        aux_wr    = i.awr;
        aux_page  = i.apage;
        acc_n     = i.acc_n;
        crst_n    = i.crst_n;
        ferr_n    = i.ferr_n;
        err_clr   = i.eclr;
        @(posedge clk);
        #1;
        if (i.rst) phase = 0;
        else if (!i.pcen_n) phase = (phase + 1) % 20;
        exp_rot = ~(20'd1 << phase);
        $display("step %0d rst=%0b en_n=%0b hreq=%0b areq=%0b -> rot=%h ack=%0b/%0b rd=%0b wr=%0b page=%h busy=%0b done=%0b err=%0b to=%0b gaux=%0b",
                 step, i.rst, i.pcen_n, i.hreq, i.areq, rot_n, host_ack, aux_ack, rdreq, wrreq,
                 cmd_page, busy, done, err, tmo, grant_aux);
        chk("rot20_n",   32'(rot_n),     32'(exp_rot));
        chk("host_ack",  32'(host_ack),  32'(e.hack));
        chk("aux_ack",   32'(aux_ack),   32'(e.aack));
        chk("rdreq",     32'(rdreq),     32'(e.rd));
        chk("wrreq",     32'(wrreq),     32'(e.wr));
        chk("cmd_page",  32'(cmd_page),  32'(e.page));
        chk("busy",      32'(busy),      32'(e.busy));
        chk("done",      32'(done),      32'(e.done));
        chk("err",       32'(err),       32'(e.err));
        chk("timeout",   32'(tmo),       32'(e.to));
        chk("grant_aux", 32'(grant_aux), 32'(e.gaux));
        step++;
    endtask

    initial begin
        // Reset, then round-robin between two continuous writers.
        add(mi(2'b10, 2'b00, 12'h000, 2'b00, 12'h000, F_NONE), me(4'b0000, 12'h000, 5'b00000));
        add(mi(2'b00, 2'b00, 12'h000, 2'b00, 12'h000, F_NONE), me(4'b0000, 12'h000, 5'b00000));
        add(mi(2'b00, 2'b11, 12'h0A1, 2'b11, 12'h0B2, F_NONE), me(4'b1001, 12'h0A1, 5'b10000));
        add(mi(2'b00, 2'b11, 12'h0A1, 2'b11, 12'h0B2, F_ACC),  me(4'b0001, 12'h0A1, 5'b10000));
        add(mi(2'b00, 2'b11, 12'h0A1, 2'b11, 12'h0B2, F_RST),  me(4'b0000, 12'h0A1, 5'b01000));
        add(mi(2'b00, 2'b11, 12'h0A1, 2'b11, 12'h0B2, F_NONE), me(4'b0101, 12'h0B2, 5'b10001));
        add(mi(2'b00, 2'b11, 12'h0A1, 2'b11, 12'h0B2, F_ACC),  me(4'b0001, 12'h0B2, 5'b10001));
        add(mi(2'b00, 2'b11, 12'h0A1, 2'b11, 12'h0B2, F_RST),  me(4'b0000, 12'h0B2, 5'b01001));
        add(mi(2'b00, 2'b11, 12'h0A1, 2'b11, 12'h0B2, F_NONE), me(4'b1001, 12'h0A1, 5'b10000));
        add(mi(2'b00, 2'b11, 12'h0A1, 2'b11, 12'h0B2, F_RST),  me(4'b0000, 12'h0A1, 5'b01000));
        add(mi(2'b00, 2'b11, 12'h0A1, 2'b11, 12'h0B2, F_NONE), me(4'b0101, 12'h0B2, 5'b10001));
        add(mi(2'b00, 2'b00, 12'h000, 2'b00, 12'h000, F_ACC),  me(4'b0001, 12'h0B2, 5'b10001));
        add(mi(2'b00, 2'b00, 12'h000, 2'b00, 12'h000, F_RST),  me(4'b0000, 12'h0B2, 5'b01001));
        add(mi(2'b00, 2'b00, 12'h000, 2'b00, 12'h000, F_NONE), me(4'b0000, 12'h0B2, 5'b00001));
        // Host read of page 0x123.
        add(mi(2'b00, 2'b10, 12'h123, 2'b00, 12'h000, F_NONE), me(4'b1010, 12'h123, 5'b10000));
        add(mi(2'b00, 2'b00, 12'h000, 2'b00, 12'h000, F_ACC),  me(4'b0010, 12'h123, 5'b10000));
        add(mi(2'b00, 2'b00, 12'h000, 2'b00, 12'h000, F_RST),  me(4'b0000, 12'h123, 5'b01000));
        add(mi(2'b00, 2'b00, 12'h000, 2'b00, 12'h000, F_NONE), me(4'b0000, 12'h123, 5'b00000));
        // Aux write aborted by FSM error coinciding with completion.
        add(mi(2'b00, 2'b00, 12'h000, 2'b11, 12'h3C5, F_NONE),    me(4'b0101, 12'h3C5, 5'b10001));
        add(mi(2'b00, 2'b00, 12'h000, 2'b00, 12'h000, F_ACC),     me(4'b0001, 12'h3C5, 5'b10001));
        add(mi(2'b00, 2'b10, 12'h055, 2'b00, 12'h000, F_ERR_RST), me(4'b0000, 12'h3C5, 5'b00101));
        add(mi(2'b00, 2'b10, 12'h055, 2'b00, 12'h000, F_NONE),    me(4'b0000, 12'h3C5, 5'b00101));
        add(mi(2'b00, 2'b10, 12'h055, 2'b00, 12'h000, F_CLR),     me(4'b0000, 12'h3C5, 5'b00001));
        add(mi(2'b00, 2'b10, 12'h055, 2'b00, 12'h000, F_NONE),    me(4'b1010, 12'h055, 5'b10000));
        add(mi(2'b00, 2'b00, 12'h000, 2'b00, 12'h000, F_ERR_CLR), me(4'b0000, 12'h055, 5'b00100));
        add(mi(2'b00, 2'b00, 12'h000, 2'b00, 12'h000, F_CLR),     me(4'b0000, 12'h055, 5'b00000));
        add(mi(2'b00, 2'b00, 12'h000, 2'b00, 12'h000, F_NONE),    me(4'b0000, 12'h055, 5'b00000));
        // Timeout: granted at step 27, wraps at steps 40 and 60, abort on the second.
        add(mi(2'b00, 2'b10, 12'h200, 2'b00, 12'h000, F_NONE), me(4'b1010, 12'h200, 5'b10000));
        for (int k = 0; k < 32; k++)
            add(mi(2'b00, 2'b00, 12'h000, 2'b00, 12'h000, F_NONE), me(4'b0010, 12'h200, 5'b10000));
        add(mi(2'b00, 2'b00, 12'h000, 2'b00, 12'h000, F_NONE), me(4'b0000, 12'h200, 5'b00010));
        add(mi(2'b00, 2'b10, 12'h201, 2'b00, 12'h000, F_NONE), me(4'b0000, 12'h200, 5'b00010));
        add(mi(2'b00, 2'b10, 12'h201, 2'b00, 12'h000, F_CLR),  me(4'b0000, 12'h200, 5'b00000));
        add(mi(2'b00, 2'b10, 12'h201, 2'b00, 12'h000, F_NONE), me(4'b1010, 12'h201, 5'b10000));
        add(mi(2'b00, 2'b00, 12'h000, 2'b00, 12'h000, F_ACC),  me(4'b0010, 12'h201, 5'b10000));
        // Reset while ACTIVE, completion requested in the same cycle: no DONE.
        add(mi(2'b10, 2'b00, 12'h000, 2'b00, 12'h000, F_RST),  me(4'b0000, 12'h000, 5'b00000));
        add(mi(2'b00, 2'b00, 12'h000, 2'b00, 12'h000, F_NONE), me(4'b0000, 12'h000, 5'b00000));

        for (int k = 0; k < tbl.size(); k++) apply(tbl[k].i, tbl[k].e);

        // Clock enable gating: nothing moves on non-tick cycles, ACK spans one tick period.
        apply(mi(2'b01, 2'b11, 12'h0F0, 2'b00, 12'h000, F_NONE), me(4'b0000, 12'h000, 5'b00000));
        apply(mi(2'b01, 2'b11, 12'h0F0, 2'b00, 12'h000, F_NONE), me(4'b0000, 12'h000, 5'b00000));
        apply(mi(2'b00, 2'b11, 12'h0F0, 2'b00, 12'h000, F_NONE), me(4'b1001, 12'h0F0, 5'b10000));
        apply(mi(2'b01, 2'b00, 12'h000, 2'b00, 12'h000, F_RST),  me(4'b1001, 12'h0F0, 5'b10000));
        apply(mi(2'b01, 2'b00, 12'h000, 2'b00, 12'h000, F_RST),  me(4'b1001, 12'h0F0, 5'b10000));
        apply(mi(2'b00, 2'b00, 12'h000, 2'b00, 12'h000, F_NONE), me(4'b0001, 12'h0F0, 5'b10000));
        // Reset on a non-tick cycle still takes effect.
        apply(mi(2'b11, 2'b00, 12'h000, 2'b00, 12'h000, F_NONE), me(4'b0000, 12'h000, 5'b00000));
        // Aux read after reset; DONE held across a disabled cycle.
        apply(mi(2'b00, 2'b00, 12'h000, 2'b10, 12'h7FF, F_NONE), me(4'b0110, 12'h7FF, 5'b10001));
        apply(mi(2'b00, 2'b00, 12'h000, 2'b00, 12'h000, F_RST),  me(4'b0000, 12'h7FF, 5'b01001));
        apply(mi(2'b01, 2'b00, 12'h000, 2'b00, 12'h000, F_NONE), me(4'b0000, 12'h7FF, 5'b01001));
        apply(mi(2'b00, 2'b00, 12'h000, 2'b00, 12'h000, F_NONE), me(4'b0000, 12'h7FF, 5'b00001));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
